// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-stage types and constants.
// Widths, NOP encoding and default reset PC.
package instr_fetch_unit_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] DEF_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  localparam fetch_entry_t EMPTY_ENTRY = '{pc: '0, instr: NOP};

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry in-order {pc, instr} queue.
// Head is slot 0; empty output shows a NOP entry.
module fetch_buffer
  import instr_fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  fetch_entry_t wdata_i,
  output fetch_entry_t rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  fetch_entry_t slot_q [2];
  fetch_entry_t slot_d [2];
  logic [1:0]   cnt_q, cnt_d;
  logic         do_pop, do_push;

  // Next-state for slots and occupancy; flush drops everything.
  always_comb begin
    slot_d[0] = slot_q[0];
    slot_d[1] = slot_q[1];
    cnt_d     = cnt_q;
    do_pop    = pop_i & (cnt_q != 2'd0);
    do_push   = push_i & ((cnt_q != 2'd2) | do_pop);
    if (flush_i) begin
      cnt_d = 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b01: begin
          slot_d[0] = slot_q[1];
          cnt_d     = cnt_q - 2'd1;
        end
        2'b10: begin
          slot_d[cnt_q[0]] = wdata_i;
          cnt_d            = cnt_q + 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd2) begin
            slot_d[0] = slot_q[1];
            slot_d[1] = wdata_i;
          end else begin
            slot_d[0] = wdata_i;
          end
        end
        default: ;
      endcase
    end
  end

  // Slot and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q[0] <= EMPTY_ENTRY;
      slot_q[1] <= EMPTY_ENTRY;
      cnt_q     <= 2'd0;
    end else begin
      slot_q[0] <= slot_d[0];
      slot_q[1] <= slot_d[1];
      cnt_q     <= cnt_d;
    end
  end

  assign empty_o = (cnt_q == 2'd0);
  assign full_o  = (cnt_q == 2'd2);
  assign rdata_o = empty_o ? EMPTY_ENTRY : slot_q[0];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC register, redirect handling,
// enqueue decision feeding a 2-entry buffer.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [ADDR_W-1:0] ADDR_STEP = 32'd1
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               id_ready,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              push, pop;
  logic              buf_full, buf_empty;
  fetch_entry_t      head, wentry;

  // Redirect wins over everything; else enqueue when a slot frees.
  always_comb begin
    pc_d = pc_q;
    push = 1'b0;
    pop  = 1'b0;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else begin
      pop  = ~buf_empty & id_ready;
      push = ~buf_full | pop;
      if (push) pc_d = pc_q + ADDR_STEP;
    end
  end

  // Fetch PC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  assign wentry = '{pc: pc_q, instr: imem_instr};

  fetch_buffer u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redirect_valid),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wentry),
    .rdata_o (head),
    .full_o  (buf_full),
    .empty_o (buf_empty)
  );

  assign imem_addr = pc_q;
  assign if_valid  = ~buf_empty;
  assign if_instr  = head.instr;
  assign if_pc     = head.pc;

endmodule
